// File: rtl/huff_code_emit_if.sv
// Symbol, table-RAM and packed-byte signals of the Huffman code emitter.
// Valid/ready: a beat transfers on a rising clk edge where valid & ready are both high; the sender holds data and valid stable until then.
interface huff_code_emit_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        sym_in;
  logic              sym_valid;
  logic              sym_last;
  logic              sym_ready;
  logic [ADDR_W-1:0] emit_addr;
  logic              emit_R;
  logic [7:0]        table_data;
  logic [7:0]        out_byte;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  sym_in, sym_valid, sym_last, table_data, out_ready,
    output sym_ready, emit_addr, emit_R, out_byte, out_valid
  );

  modport slave (
    output sym_in, sym_valid, sym_last, table_data, out_ready,
    input  sym_ready, emit_addr, emit_R, out_byte, out_valid
  );
endinterface

// File: rtl/huff_code_emit.sv
// Huffman code emitter: looks up each symbol's length/code in the table RAM and packs codes MSB-first into bytes.
// Optional HUFF_BIT_COUNT_EN adds total_bits, the summed code length of all accepted symbols.
module huff_code_emit #(
  parameter int ADDR_W    = 10,
  parameter int LEN_BASE  = 0,
  parameter int CODE_BASE = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  huff_code_emit_if.master     bus,
  input  logic                 emit_start,
  output logic                 sym_err,
  output logic                 emit_finish,
`ifdef HUFF_BIT_COUNT_EN
  output logic [15:0]          total_bits,
`endif
  output logic [3:0]           dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_GET     = 4'd1,
    S_RD_LEN  = 4'd2,
    S_LWAIT   = 4'd3,
    S_RD_CODE = 4'd4,
    S_CWAIT   = 4'd5,
    S_APPEND  = 4'd6,
    S_EMIT    = 4'd7,
    S_FLUSH   = 4'd8,
    S_DONE    = 4'd9
  } state_t;

  localparam logic [ADDR_W-1:0] LEN_A  = ADDR_W'(LEN_BASE);
  localparam logic [ADDR_W-1:0] CODE_A = ADDR_W'(CODE_BASE);

  state_t      state;
  logic [6:0]  sym_r;
  logic        last_r;
  logic [3:0]  len_r;
  logic [7:0]  code_r;
  logic [15:0] acc;
  logic [3:0]  nbits;

  logic [3:0]  tbl_len;
  logic        len_bad;
  logic [15:0] code_mask;
  logic [15:0] append_bits;
  logic [15:0] acc_next;
  logic [4:0]  nbits_sum;

  assign dbg_state = state;

  // The code byte may carry junk below its length, so only the top len bits are kept.
  always_comb begin
    tbl_len     = bus.table_data[3:0];
    len_bad     = (tbl_len == 4'd0) || (tbl_len > 4'd8);
    code_mask   = ~(16'hFFFF >> len_r);
    append_bits = ({code_r, 8'h00} & code_mask) >> nbits;
    acc_next    = acc | append_bits;
    nbits_sum   = {1'b0, nbits} + {1'b0, len_r};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      sym_r         <= '0;
      last_r        <= 1'b0;
      len_r         <= '0;
      code_r        <= '0;
      acc           <= '0;
      nbits         <= '0;
      sym_err       <= 1'b0;
      emit_finish   <= 1'b0;
      bus.sym_ready <= 1'b0;
      bus.emit_addr <= '0;
      bus.emit_R    <= 1'b0;
      bus.out_byte  <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      sym_err     <= 1'b0;
      emit_finish <= 1'b0;
      case (state)
        S_IDLE: begin
          if (emit_start) begin
            state         <= S_GET;
            bus.sym_ready <= 1'b1;
          end
        end
        S_GET: begin
          if (bus.sym_valid && bus.sym_ready) begin
            sym_r  <= bus.sym_in[6:0];
            last_r <= bus.sym_last;
            if (bus.sym_in[7]) begin
              sym_err <= 1'b1;
              if (bus.sym_last) begin
                state         <= S_FLUSH;
                bus.sym_ready <= 1'b0;
              end
            end else begin
              bus.sym_ready <= 1'b0;
              bus.emit_addr <= LEN_A + ADDR_W'(bus.sym_in[6:0]);
              bus.emit_R    <= 1'b1;
              state         <= S_RD_LEN;
            end
          end
        end
        S_RD_LEN: state <= S_LWAIT;
        S_LWAIT: begin
          len_r <= tbl_len;
          if (len_bad) begin
            sym_err    <= 1'b1;
            bus.emit_R <= 1'b0;
            if (last_r) begin
              state <= S_FLUSH;
            end else begin
              state         <= S_GET;
              bus.sym_ready <= 1'b1;
            end
          end else begin
            bus.emit_addr <= CODE_A + ADDR_W'(sym_r);
            state         <= S_RD_CODE;
          end
        end
        S_RD_CODE: state <= S_CWAIT;
        S_CWAIT: begin
          code_r     <= bus.table_data;
          bus.emit_R <= 1'b0;
          state      <= S_APPEND;
        end
        S_APPEND: begin
          acc   <= acc_next;
          nbits <= nbits_sum[3:0];
          if (nbits_sum[3]) begin
            bus.out_byte  <= acc_next[15:8];
            bus.out_valid <= 1'b1;
            state         <= S_EMIT;
          end else if (last_r) begin
            state <= S_FLUSH;
          end else begin
            state         <= S_GET;
            bus.sym_ready <= 1'b1;
          end
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            acc           <= {acc[7:0], 8'h00};
            nbits         <= nbits - 4'd8;
            if (last_r) begin
              state <= S_FLUSH;
            end else begin
              state         <= S_GET;
              bus.sym_ready <= 1'b1;
            end
          end
        end
        S_FLUSH: begin
          // A partial byte is presented one cycle after entry; an empty accumulator finishes at once.
          if (bus.out_valid) begin
            if (bus.out_ready) begin
              bus.out_valid <= 1'b0;
              nbits         <= '0;
              acc           <= '0;
              emit_finish   <= 1'b1;
              state         <= S_DONE;
            end
          end else if (nbits != 4'd0) begin
            bus.out_byte  <= acc[15:8];
            bus.out_valid <= 1'b1;
          end else begin
            emit_finish <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          acc   <= '0;
          nbits <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef HUFF_BIT_COUNT_EN
  logic [16:0] bits_sum;

  always_comb begin
    bits_sum = {1'b0, total_bits} + 17'(tbl_len);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_bits <= '0;
    end else if (state == S_IDLE && emit_start) begin
      total_bits <= '0;
    end else if (state == S_LWAIT && !len_bad) begin
      total_bits <= bits_sum[16] ? 16'hFFFF : bits_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_huff_code_emit.sv
// Directed bench for huff_code_emit: small table RAM model, symbol driver, byte scoreboard.
module tb_huff_code_emit;

  logic        clk;
  logic        reset;
  logic        emit_start;
  logic        sym_err;
  logic        emit_finish;
  logic [3:0]  dbg_state;
`ifdef HUFF_BIT_COUNT_EN
  logic [15:0] total_bits;
`endif

  huff_code_emit_if #(.ADDR_W(10)) bus_if ();

  huff_code_emit #(.ADDR_W(10), .LEN_BASE(0), .CODE_BASE(128)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus_if),
    .emit_start  (emit_start),
    .sym_err     (sym_err),
    .emit_finish (emit_finish),
`ifdef HUFF_BIT_COUNT_EN
    .total_bits  (total_bits),
`endif
    .dbg_state   (dbg_state)
  );

  int n_vec = 0;
  int n_err = 0;
  int err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mem [0:1023];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  // table RAM model: one-cycle read latency
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[0] = 8'd2; mem[128] = 8'b0100_0000;
    mem[1] = 8'd4; mem[129] = 8'b1011_0000;
    mem[2] = 8'd4; mem[130] = 8'b1010_0000;
    mem[3] = 8'd2; mem[131] = 8'b0000_0000;
    mem[4] = 8'd3; mem[132] = 8'b1000_0000;
    mem[5] = 8'd2; mem[133] = 8'b1100_0000;
  end

  always @(posedge clk) begin
    if (bus_if.emit_R) bus_if.table_data <= mem[bus_if.emit_addr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: bytes are taken at the edge following a negedge with valid & ready
  always @(negedge clk) begin
    if (sym_err) err_cnt++;
    if (reset && bus_if.out_valid && bus_if.out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_byte", {8'h00, bus_if.out_byte}, 16'hFFFF);
      end else begin
        check("out_byte", {8'h00, bus_if.out_byte}, {8'h00, exp_q.pop_front()});
      end
    end
  end

  // drivers
  task automatic start_stream();
    emit_start = 1'b1;
    @(posedge clk); #1;
    emit_start = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] s, input logic last);
    logic done = 1'b0;
    bus_if.sym_in    = s;
    bus_if.sym_last  = last;
    bus_if.sym_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (bus_if.sym_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    bus_if.sym_valid = 1'b0;
    bus_if.sym_last  = 1'b0;
    check("sym_accept", {15'd0, done}, 16'd1);
  endtask

  task automatic wait_finish(input string tag);
    logic found = 1'b0;
    for (int i = 0; i < 500 && !found; i++) begin
      @(negedge clk);
      if (emit_finish) found = 1'b1;
    end
    check(tag, {15'd0, found}, 16'd1);
    check("bytes_pending", 16'(exp_q.size()), 16'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sym_ready"}, {15'd0, bus_if.sym_ready}, 16'd0);
    check({tag, "_emit_addr"}, 16'(bus_if.emit_addr), 16'd0);
    check({tag, "_emit_R"}, {15'd0, bus_if.emit_R}, 16'd0);
    check({tag, "_out_byte"}, {8'd0, bus_if.out_byte}, 16'd0);
    check({tag, "_out_valid"}, {15'd0, bus_if.out_valid}, 16'd0);
    check({tag, "_sym_err"}, {15'd0, sym_err}, 16'd0);
    check({tag, "_emit_finish"}, {15'd0, emit_finish}, 16'd0);
    check({tag, "_state"}, {12'd0, dbg_state}, 16'd0);
  endtask

  initial begin
    logic seen;
    reset = 1'b0;
    emit_start = 1'b0;
    bus_if.sym_in = 8'h00;
    bus_if.sym_valid = 1'b0;
    bus_if.sym_last = 1'b0;
    bus_if.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("rst");
`ifdef HUFF_BIT_COUNT_EN
    check("rst_total_bits", total_bits, 16'd0);
`endif
    reset = 1'b1;
    @(posedge clk); #1;

    // A,B(last): 01 1011 + pad -> 0x6C
    exp_q.push_back(8'h6C);
    start_stream();
    send_sym(8'd0, 1'b0);
    send_sym(8'd1, 1'b1);
    wait_finish("t1_finish");
`ifdef HUFF_BIT_COUNT_EN
    check("t1_total_bits", total_bits, 16'd6);
`endif

    // F x4: exactly one full byte, no pad byte
    exp_q.push_back(8'hFF);
    start_stream();
    for (int i = 0; i < 4; i++) send_sym(8'd5, i == 3);
    wait_finish("t2_finish");
`ifdef HUFF_BIT_COUNT_EN
    check("t2_total_bits", total_bits, 16'd8);
`endif

    // B,C,E(last): 1011 1010 | 100 -> 0xBA, 0x80
    exp_q.push_back(8'hBA);
    exp_q.push_back(8'h80);
    start_stream();
    send_sym(8'd1, 1'b0);
    send_sym(8'd2, 1'b0);
    send_sym(8'd4, 1'b1);
    wait_finish("t3_finish");
`ifdef HUFF_BIT_COUNT_EN
    check("t3_total_bits", total_bits, 16'd11);
`endif

    // B,C(last) with back-pressure; a stray emit_start must be ignored
    bus_if.out_ready = 1'b0;
    exp_q.push_back(8'hBA);
    start_stream();
    send_sym(8'd1, 1'b0);
    send_sym(8'd2, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (bus_if.out_valid) seen = 1'b1;
    end
    check("t4_valid_seen", {15'd0, seen}, 16'd1);
    @(posedge clk); #1;
    emit_start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t4_hold_valid", {15'd0, bus_if.out_valid}, 16'd1);
      check("t4_hold_byte", {8'd0, bus_if.out_byte}, 16'h00BA);
      @(posedge clk); #1;
      emit_start = 1'b0;
    end
    bus_if.out_ready = 1'b1;
    wait_finish("t4_finish");
`ifdef HUFF_BIT_COUNT_EN
    check("t4_total_bits", total_bits, 16'd8);
`endif

    // bit7 symbol and zero-length symbol are dropped with sym_err
    err_cnt = 0;
    exp_q.push_back(8'h40);
    start_stream();
    send_sym(8'h85, 1'b0);
    send_sym(8'd7, 1'b0);
    send_sym(8'd0, 1'b1);
    wait_finish("t5_finish");
    check("t5_sym_err_count", 16'(err_cnt), 16'd2);
`ifdef HUFF_BIT_COUNT_EN
    check("t5_total_bits", total_bits, 16'd2);
`endif

    // asynchronous reset in CWAIT, then a fresh D(last) stream
    start_stream();
    send_sym(8'd1, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (dbg_state == 4'd5) seen = 1'b1;
    end
    check("t6_cwait_seen", {15'd0, seen}, 16'd1);
    check("t6_emit_R_before", {15'd0, bus_if.emit_R}, 16'd1);
    reset = 1'b0;
    #1;
    check_all_zero("t6_rst");
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(8'h00);
    start_stream();
    send_sym(8'd3, 1'b1);
    wait_finish("t6_finish");
`ifdef HUFF_BIT_COUNT_EN
    check("t6_total_bits", total_bits, 16'd2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
